// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin sharing of the physical memory port between the I-cache and D-cache
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state;
  logic last_d;
  logic i_req, d_req, grant_i, grant_d;
  always_comb begin
    i_req = i_pmem_read;
    d_req = d_pmem_read | d_pmem_write;
    grant_i = i_req & (~d_req | last_d);
    grant_d = d_req & (~i_req | ~last_d);
    i_pmem_resp = (state == SERVE_I) & pmem_resp;
    d_pmem_resp = (state == SERVE_D) & pmem_resp;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_d <= 1'b1;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_address <= '0;
      pmem_wdata <= '0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        state <= SERVE_I;
        last_d <= 1'b0;
        pmem_read <= 1'b1;
        pmem_write <= 1'b0;
        pmem_address <= i_pmem_address;
      end else if (grant_d) begin
        state <= SERVE_D;
        last_d <= 1'b1;
        pmem_read <= ~d_pmem_write;
        pmem_write <= d_pmem_write;
        pmem_address <= d_pmem_address;
        pmem_wdata <= d_pmem_wdata;
      end
    end else if (pmem_resp) begin
      state <= IDLE;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_pmem_arbiter;
  logic clk, rst;
  logic i_pmem_read;
  logic [15:0] i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic i_pmem_resp;
  logic d_pmem_read, d_pmem_write;
  logic [15:0] d_pmem_address;
  logic [127:0] d_pmem_wdata, d_pmem_rdata;
  logic d_pmem_resp;
  logic pmem_read, pmem_write;
  logic [15:0] pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic pmem_resp;
  int checks = 0;
  int errors = 0;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = 16'h0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = 16'h0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got rd=%b wr=%b iresp=%b dresp=%b, want all 0", pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
    end
    checks++;
    if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h, want 0", pmem_address, pmem_wdata);
    end
  endtask

  task automatic test_i_read();
    logic [127:0] rd;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    tick();
    i_pmem_address = 16'hFFFF;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230 || i_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL i_read_grant: got rd=%b wr=%b addr=%h iresp=%b, want 1 0 1230 0", pmem_read, pmem_write, pmem_address, i_pmem_resp);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h1230 || i_pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL i_read_hold c%0d: got rd=%b addr=%h iresp=%b, want 1 1230 0", c, pmem_read, pmem_address, i_pmem_resp);
      end
    end
    tick();
    rd = rand_line();
    pmem_resp = 1'b1; pmem_rdata = rd; i_pmem_read = 1'b0;
    #1;
    checks++;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== rd || d_pmem_rdata !== rd) begin
      errors++;
      $display("FAIL i_read_resp: got iresp=%b dresp=%b irdata=%h, want 1 0 %h", i_pmem_resp, d_pmem_resp, i_pmem_rdata, rd);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL i_read_idle: got rd=%b iresp=%b, want 0 0", pmem_read, i_pmem_resp);
    end
  endtask

  task automatic test_d_write();
    logic [127:0] wd;
    wd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    d_pmem_write = 1'b1; d_pmem_address = 16'h4560; d_pmem_wdata = wd;
    for (int c = 1; c <= 3; c++) begin
      tick();
      d_pmem_wdata = ~wd; d_pmem_address = 16'h0;
      #1;
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4560 || pmem_wdata !== wd || d_pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL d_write_hold c%0d: got wr=%b rd=%b addr=%h wdata=%h dresp=%b", c, pmem_write, pmem_read, pmem_address, pmem_wdata, d_pmem_resp);
      end
    end
    pmem_resp = 1'b1; d_pmem_write = 1'b0;
    #1;
    checks++;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL d_write_resp: got dresp=%b iresp=%b, want 1 0", d_pmem_resp, i_pmem_resp);
    end
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL d_write_once: got wr=%b dresp=%b, want 0 0", pmem_write, d_pmem_resp);
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_tie_alternate();
    logic exp_i;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2) == 0;
      tick();
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== (exp_i ? 16'h1000 : 16'h2000)) begin
        errors++;
        $display("FAIL tie_grant k%0d: got rd=%b addr=%h, want 1 %h", k, pmem_read, pmem_address, exp_i ? 16'h1000 : 16'h2000);
      end
      tick();
      tick();
      pmem_resp = 1'b1; pmem_rdata = rand_line();
      #1;
      checks++;
      if (i_pmem_resp !== exp_i || d_pmem_resp !== !exp_i) begin
        errors++;
        $display("FAIL tie_resp k%0d: got iresp=%b dresp=%b, want %b %b", k, i_pmem_resp, d_pmem_resp, exp_i, !exp_i);
      end
      tick();
      pmem_resp = 1'b0;
      if (k == 3) begin
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      end
      #1;
      checks++;
      if (pmem_read !== 1'b0) begin
        errors++;
        $display("FAIL tie_gap k%0d: got rd=%b, want 0", k, pmem_read);
      end
    end
    tick();
  endtask

  task automatic test_drop();
    d_pmem_read = 1'b1; d_pmem_address = 16'h0800; d_pmem_wdata = rand_line();
    tick();
    d_pmem_read = 1'b0; d_pmem_address = 16'h0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h0800) begin
        errors++;
        $display("FAIL drop_hold c%0d: got rd=%b addr=%h, want 1 0800", c, pmem_read, pmem_address);
      end
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (d_pmem_resp !== 1'b1) begin
      errors++;
      $display("FAIL drop_resp: got dresp=%b, want 1", d_pmem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got rd=%b, want 0", pmem_read);
    end
  endtask

  task automatic test_reset_mid();
    i_pmem_read = 1'b1; i_pmem_address = 16'h3330;
    tick();
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3330) begin
      errors++;
      $display("FAIL rstmid_grant: got rd=%b addr=%h, want 1 3330", pmem_read, pmem_address);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; i_pmem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL rstmid_clear: got rd=%b wr=%b iresp=%b dresp=%b addr=%h wdata=%h, want all 0", pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata);
    end
    pmem_resp = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h3440;
    d_pmem_read = 1'b1; d_pmem_address = 16'h5440;
    tick();
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3440) begin
      errors++;
      $display("FAIL rstmid_tie: got rd=%b addr=%h, want 1 3440", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
  endtask

  task automatic test_spurious_and_rw();
    logic [127:0] wd;
    for (int c = 0; c < 3; c++) begin
      pmem_resp = 1'b1;
      #1;
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
        errors++;
        $display("FAIL spurious c%0d: got rd=%b wr=%b iresp=%b dresp=%b, want all 0", c, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
      end
      tick();
    end
    pmem_resp = 1'b0;
    wd = rand_line();
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h5550; d_pmem_wdata = wd;
    tick();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h5550 || pmem_wdata !== wd) begin
      errors++;
      $display("FAIL rw_both: got wr=%b rd=%b addr=%h wdata=%h, want 1 0 5550 %h", pmem_write, pmem_read, pmem_address, pmem_wdata, wd);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (d_pmem_resp !== 1'b1) begin
      errors++;
      $display("FAIL rw_both_resp: got dresp=%b, want 1", d_pmem_resp);
    end
    tick();
    pmem_resp = 1'b0;
  endtask

  // Transaction-level model: who owns memory, what was latched, and whose turn a tie is.
  task automatic test_random();
    int owner, cnt, grants_i, grants_d;
    logic last_d, m_wr, r, i_pend, d_pend, d_wr, d_rd;
    logic [15:0] m_addr;
    logic [127:0] m_wdata, rd;
    rst = 1'b1;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    tick();
    rst = 1'b0;
    owner = 0; cnt = 0; last_d = 1'b1; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0; d_rd = 1'b0;
    grants_i = 0; grants_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if (pmem_read !== (owner != 0 && !m_wr) || pmem_write !== (owner != 0 && m_wr) ||
          (owner != 0 && pmem_address !== m_addr) || (owner == 2 && m_wr && pmem_wdata !== m_wdata)) begin
        errors++;
        $display("FAIL rand_port cyc%0d: got rd=%b wr=%b addr=%h, want owner=%0d wr=%b addr=%h", cyc, pmem_read, pmem_write, pmem_address, owner, m_wr, m_addr);
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_pmem_address = 16'($urandom());
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        case ($urandom_range(0, 2))
          0: begin d_rd = 1'b1; d_wr = 1'b0; end
          1: begin d_rd = 1'b0; d_wr = 1'b1; end
          default: begin d_rd = 1'b1; d_wr = 1'b1; end
        endcase
        d_pmem_address = 16'($urandom()); d_pmem_wdata = rand_line();
      end
      if (owner == 1 && $urandom_range(0, 3) == 0) i_pmem_address = 16'($urandom());
      if (owner == 2 && $urandom_range(0, 3) == 0) d_pmem_wdata = rand_line();
      if (owner == 1 && $urandom_range(0, 9) == 0) i_pend = 1'b0;
      if (owner == 2 && $urandom_range(0, 9) == 0) d_pend = 1'b0;
      i_pmem_read = i_pend;
      d_pmem_read = d_pend & d_rd;
      d_pmem_write = d_pend & d_wr;
      if (owner != 0) begin
        cnt--;
        r = cnt == 0;
      end else r = $urandom_range(0, 7) == 0;
      rd = rand_line();
      pmem_resp = r; pmem_rdata = rd;
      #1;
      checks++;
      if (i_pmem_resp !== (owner == 1 && r) || d_pmem_resp !== (owner == 2 && r) || i_pmem_rdata !== rd || d_pmem_rdata !== rd) begin
        errors++;
        $display("FAIL rand_resp cyc%0d: got iresp=%b dresp=%b, want owner=%0d resp=%b", cyc, i_pmem_resp, d_pmem_resp, owner, r);
      end
      if (owner != 0) begin
        if (r) begin
          if (owner == 1) i_pend = 1'b0; else d_pend = 1'b0;
          owner = 0;
        end
      end else if (i_pend && (!d_pend || last_d)) begin
        owner = 1; m_addr = i_pmem_address; m_wr = 1'b0; last_d = 1'b0;
        cnt = $urandom_range(1, 4); grants_i++;
      end else if (d_pend) begin
        owner = 2; m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_wr = d_wr; last_d = 1'b1;
        cnt = $urandom_range(1, 4); grants_d++;
      end
      tick();
    end
    $display("random traffic: %0d I grants, %0d D grants", grants_i, grants_d);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_tie_alternate();
    test_drop();
    test_reset_mid();
    test_spurious_and_rw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
